note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Sequences playback of one song: fetches {note,duration} words from the song ROM, loads each duration
//  into the external beat_timer, presents the note to the tone generator, and advances on timer_done.
//  Owns play/pause, restart and repeat; gates the beat enable seen by beat_timer so pause freezes the count.
// PARAMETERS
//  ADDR_BITS  7  song ROM address width; song length <= 2**ADDR_BITS words
//  NOTE_BITS  6  note code width; note 0 = rest (silence)
//  DUR_BITS   6  duration width in beats; must equal beat_timer duration_to_load width
// PORTS
//  clk              in   1                    system clock, all logic rising-edge
//  rst_n            in   1                    asynchronous, active-low reset
//  beat_in          in   1                    1-cycle beat tick from beat generator
//  play_pause       in   1                    1-cycle pulse: toggles playing
//  restart          in   1                    1-cycle pulse: return to address 0
//  repeat_en        in   1                    level: loop song at end instead of stopping
//  rom_addr         out  ADDR_BITS            song ROM address (ROM read latency = 1 cycle)
//  rom_data         in   NOTE_BITS+DUR_BITS   {note[msb], duration[lsb]}
//  timer_beat       out  1                    beat enable to beat_timer
//  duration_to_load out  DUR_BITS             duration held for beat_timer comparison
//  timer_clear      out  1                    1-cycle clear to beat_timer counter
//  timer_done       in   1                    beat_timer: final beat of current note
//  note_out         out  NOTE_BITS            current note to tone generator
//  new_note         out  1                    1-cycle strobe, note_out/duration changed
//  playing          out  1                    1 = running, 0 = paused/stopped
//  song_done        out  1                    1-cycle pulse at end of song
// BEHAVIOUR
//  Reset: state IDLE, rom_addr=0, note_out=0, duration_to_load=0, playing=0; pulses 0; timer_clear=1 in IDLE.
//  States: IDLE -> FETCH -> LOAD -> WAIT -> (ADVANCE -> FETCH | END).
//   IDLE: timer_clear held 1. play_pause pulse -> playing=1, go FETCH.
//   FETCH: rom_addr stable, 1 cycle for ROM data; -> LOAD.
//   LOAD: if duration field==0 (end marker) -> END, nothing loaded. Else register note/duration,
//         pulse timer_clear and new_note in this cycle; -> WAIT.
//   WAIT: timer_beat = beat_in & playing. On timer_done -> ADVANCE. Note lasts exactly duration beats:
//         timer_done is on the duration-th gated beat after LOAD.
//   ADVANCE: rom_addr+1; if rom_addr == 2**ADDR_BITS-1 -> END (no wrap), else -> FETCH.
//   END: song_done pulse 1 cycle, note_out=0. If repeat_en: rom_addr=0 -> FETCH (playing stays 1).
//        Else playing=0, rom_addr=0 -> IDLE.
//  Latency: timer_done to new_note of next note = 3 cycles (ADVANCE, FETCH, LOAD).
//  timer_beat is 0 in every state except WAIT; timer_done outside WAIT ignored.
//  play_pause outside IDLE toggles playing; paused in WAIT freezes beat count, note_out held.
//  play_pause in FETCH/LOAD/ADVANCE toggles playing; sequencing continues to WAIT, then freezes.
//  restart (any state except IDLE): rom_addr=0, timer_clear pulse, -> FETCH, playing unchanged.
//  restart in IDLE: ignored (already at 0).
//  restart + play_pause same cycle: restart wins, toggle discarded.
//  restart + timer_done same cycle: restart wins, no ADVANCE.
//  rst_n low mid-note: immediate return to reset values, no song_done.
//  Widths: rom_addr increments modulo 2**ADDR_BITS but wrap is never taken (END at max).
// STRUCTURE
//  music_pkg: state enum (IDLE, FETCH, LOAD, WAIT, ADVANCE, END), ADDR_BITS/NOTE_BITS/DUR_BITS defaults,
//  END_MARKER_DUR = 0, NOTE_REST = 0.
//  Single FSM module, no sub-module. beat_timer and song ROM are instantiated beside it in the player top.
// TESTING  (bench models 1-cycle ROM and real beat_timer; beat_in every 4 clks)
//  ROM {5,3},{7,1},{x,0}; pulse play -> new_note note=5 dur=3; after 3 beats note=7; after 1 beat song_done,
//   playing=0, IDLE.
//  Same song, repeat_en=1 -> after song_done, new_note note=5 at addr 0 within 3 cycles, playing=1.
//  Pause after 1 beat of note 5 for 20 beats -> timer_beat=0, no timer_done. Resume -> 2 more beats to note 7.
//  restart during note 7 -> timer_clear pulse, rom_addr=0, next new_note note=5 dur=3.
//  restart and play_pause same cycle in WAIT -> playing unchanged, rom_addr=0.
//  ROM full of dur=1 with no marker, ADDR_BITS=3 -> 8 notes then song_done, rom_addr never wraps mid-song.
//  rst_n low mid-note -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and defaults for the song playback path.
package music_pkg;

    localparam int unsigned ADDR_BITS_DEF  = 7;
    localparam int unsigned NOTE_BITS_DEF  = 6;
    localparam int unsigned DUR_BITS_DEF   = 6;
    localparam int unsigned END_MARKER_DUR = 0;
    localparam int unsigned NOTE_REST      = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT,
        ST_ADVANCE,
        ST_END
    } state_e;

endpackage

// File: rtl/note_sequencer.sv
// Walks the song ROM one {note,duration} word at a time, drives beat_timer and
// the tone generator, and owns play/pause, restart and repeat.
module note_sequencer
    import music_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
    parameter int unsigned NOTE_BITS = NOTE_BITS_DEF,
    parameter int unsigned DUR_BITS  = DUR_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          beat_in,
    input  logic                          play_pause,
    input  logic                          restart,
    input  logic                          repeat_en,
    output logic [ADDR_BITS-1:0]          rom_addr,
    input  logic [NOTE_BITS+DUR_BITS-1:0] rom_data,
    output logic                          timer_beat,
    output logic [DUR_BITS-1:0]           duration_to_load,
    output logic                          timer_clear,
    input  logic                          timer_done,
    output logic [NOTE_BITS-1:0]          note_out,
    output logic                          new_note,
    output logic                          playing,
    output logic                          song_done
);

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q,  addr_d;
    logic [NOTE_BITS-1:0]   note_q,  note_d;
    logic [DUR_BITS-1:0]    dur_q,   dur_d;
    logic                   playing_q, playing_d;

    logic [NOTE_BITS-1:0]   rom_note;
    logic [DUR_BITS-1:0]    rom_dur;
    logic                   restart_act;

    assign rom_note    = rom_data[NOTE_BITS+DUR_BITS-1 -: NOTE_BITS];
    assign rom_dur     = rom_data[DUR_BITS-1:0];
    assign restart_act = restart && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            note_q    <= '0;
            dur_q     <= '0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            note_q    <= note_d;
            dur_q     <= dur_d;
            playing_q <= playing_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        note_d      = note_q;
        dur_d       = dur_q;
        playing_d   = playing_q;
        timer_clear = 1'b0;
        timer_beat  = 1'b0;
        new_note    = 1'b0;
        song_done   = 1'b0;

        if (play_pause) begin
            playing_d = !playing_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (play_pause) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (rom_dur == DUR_BITS'(END_MARKER_DUR)) begin
                    note_d  = NOTE_BITS'(NOTE_REST);
                    state_d = ST_END;
                end else begin
                    note_d      = rom_note;
                    dur_d       = rom_dur;
                    timer_clear = 1'b1;
                    new_note    = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_beat = beat_in && playing_q;
                if (timer_done) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                // The last ROM word never wraps back to 0 mid-song.
                if (addr_q == ADDR_MAX) begin
                    note_d  = NOTE_BITS'(NOTE_REST);
                    state_d = ST_END;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_END: begin
                song_done = 1'b1;
                addr_d    = '0;
                if (repeat_en) begin
                    state_d = ST_FETCH;
                end else begin
                    playing_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Restart overrides every other transition, including a same-cycle toggle or load.
        if (restart_act) begin
            addr_d      = '0;
            note_d      = note_q;
            dur_d       = dur_q;
            playing_d   = playing_q;
            new_note    = 1'b0;
            timer_clear = 1'b1;
            state_d     = ST_FETCH;
        end
    end

    // Present the freshly fetched note in the same cycle as its strobe.
    assign note_out         = new_note ? rom_note : note_q;
    assign duration_to_load = new_note ? rom_dur  : dur_q;
    assign rom_addr         = addr_q;
    assign playing          = playing_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a 1-cycle ROM and beat_timer model.
module tb_note_sequencer;

    localparam int AB = 3;
    localparam int NB = 6;
    localparam int DB = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          beat_in = 1'b0;
    logic          play_pause;
    logic          restart;
    logic          repeat_en;
    logic [AB-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic          timer_beat;
    logic [DB-1:0] duration_to_load;
    logic          timer_clear;
    logic          timer_done;
    logic [NB-1:0] note_out;
    logic          new_note;
    logic          playing;
    logic          song_done;

    always #5 clk = ~clk;

    note_sequencer #(.ADDR_BITS(AB), .NOTE_BITS(NB), .DUR_BITS(DB)) dut (
        .clk(clk), .rst_n(rst_n), .beat_in(beat_in), .play_pause(play_pause),
        .restart(restart), .repeat_en(repeat_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .timer_beat(timer_beat),
        .duration_to_load(duration_to_load), .timer_clear(timer_clear),
        .timer_done(timer_done), .note_out(note_out), .new_note(new_note),
        .playing(playing), .song_done(song_done)
    );

    // Song ROM with one cycle of read latency.
    logic [11:0] rom [8];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Beat timer: done on the duration-th enabled beat since the last clear.
    int unsigned tcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           tcnt <= 0;
        else if (timer_clear) tcnt <= 0;
        else if (timer_beat)  tcnt <= (tcnt + 1 >= 32'(duration_to_load)) ? 0 : tcnt + 1;
    end
    assign timer_done = timer_beat && (tcnt + 1 == 32'(duration_to_load));

    // Beat tick every 4 clocks.
    logic [1:0] bdiv = 2'd0;
    always @(negedge clk) begin
        bdiv    <= bdiv + 2'd1;
        beat_in <= (bdiv == 2'd3);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Event monitor, sampled mid-cycle.
    int cyc = 0, n_new, n_done, n_td, tot_beats, cur_beats, cur_dur, note_sum;
    int td_cyc, last_lat, done_cyc, new_cyc;
    bit have_note;
    int q_notes[$], q_durs[$], q_beats[$];

    always begin
        @(negedge clk);
        #3;
        cyc++;
        if (rst_n) begin
            if (timer_beat) begin tot_beats++; cur_beats++; end
            if (timer_done) begin n_td++; td_cyc = cyc; end
            if (new_note) begin
                if (have_note) q_beats.push_back(cur_beats);
                have_note = 1'b1;
                cur_beats = 0;
                cur_dur   = int'(duration_to_load);
                n_new++;
                note_sum += int'(note_out);
                q_notes.push_back(int'(note_out));
                q_durs.push_back(int'(duration_to_load));
                last_lat  = cyc - td_cyc;
                new_cyc   = cyc;
            end
            if (song_done) begin
                if (have_note) q_beats.push_back(cur_beats);
                have_note = 1'b0;
                n_done++;
                done_cyc  = cyc;
            end
        end
    end

    task automatic clear_mon();
        n_new = 0; n_done = 0; n_td = 0; tot_beats = 0; cur_beats = 0; cur_dur = 0;
        note_sum = 0; td_cyc = -100; last_lat = -1; done_cyc = 0; new_cyc = 0;
        have_note = 1'b0;
        q_notes.delete(); q_durs.delete(); q_beats.delete();
    endtask

    task automatic do_reset();
        play_pause = 1'b0; restart = 1'b0; repeat_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_pp();
        @(negedge clk); play_pause = 1'b1;
        @(negedge clk); play_pause = 1'b0;
    endtask

    // which: 0 = new_note count, 1 = song_done count, 2 = beats of current note
    task automatic wait_for(input string nm, input int which, input int target, input int maxc);
        bit ok = 1'b0;
        int v;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #4;
            v = (which == 0) ? n_new : (which == 1) ? n_done : cur_beats;
            if (v >= target) begin ok = 1'b1; break; end
        end
        if (!ok) chk({nm, "_timeout"}, v, target);
    endtask

    function automatic logic [11:0] mk(input int n, input int d);
        return {6'(n), 6'(d)};
    endfunction

    typedef struct {
        logic [7:0][11:0] w;
        int exp_notes;
        int exp_beats;
        int exp_sum;
    } song_t;

    song_t tbl[5];

    initial begin
        int b0, td0, nd, exp_n[$], exp_d[$];
        logic [7:0][11:0] s0;

        foreach (rom[i]) rom[i] = '0;
        do_reset();
        #1;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_note_out", int'(note_out), 0);
        chk("rst_duration", int'(duration_to_load), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_timer_clear", int'(timer_clear), 1);
        chk("rst_new_note", int'(new_note), 0);
        chk("rst_song_done", int'(song_done), 0);
        chk("rst_timer_beat", int'(timer_beat), 0);

        s0 = '0;
        s0[0] = mk(5, 3); s0[1] = mk(7, 1);
        tbl[0].w = s0;           tbl[0].exp_notes = 2; tbl[0].exp_beats = 4;  tbl[0].exp_sum = 12;
        tbl[1].w = '0;           tbl[1].exp_notes = 0; tbl[1].exp_beats = 0;  tbl[1].exp_sum = 0;
        tbl[2].w = '0;
        tbl[2].w[0] = mk(9, 2); tbl[2].w[1] = mk(0, 5);
        tbl[2].exp_notes = 2;    tbl[2].exp_beats = 7;  tbl[2].exp_sum = 9;
        for (int i = 0; i < 8; i++) tbl[3].w[i] = mk(i + 1, 1);
        tbl[3].exp_notes = 8;    tbl[3].exp_beats = 8;  tbl[3].exp_sum = 36;
        tbl[4].w = '0;
        tbl[4].w[0] = mk(63, 63); tbl[4].w[1] = mk(1, 0);
        tbl[4].exp_notes = 1;    tbl[4].exp_beats = 63; tbl[4].exp_sum = 63;

        foreach (tbl[t]) begin
            do_reset();
            for (int i = 0; i < 8; i++) rom[i] = tbl[t].w[i];
            clear_mon();
            pulse_pp();
            wait_for($sformatf("tbl%0d_done", t), 1, 1, 2000);
            repeat (3) @(negedge clk);
            #4;
            chk($sformatf("tbl%0d_notes", t), n_new, tbl[t].exp_notes);
            chk($sformatf("tbl%0d_beats", t), tot_beats, tbl[t].exp_beats);
            chk($sformatf("tbl%0d_sum", t), note_sum, tbl[t].exp_sum);
            chk($sformatf("tbl%0d_done", t), n_done, 1);
            chk($sformatf("tbl%0d_playing", t), int'(playing), 0);
            chk($sformatf("tbl%0d_addr", t), int'(rom_addr), 0);
        end

        // First note, pause for 20 beats, resume, then note-to-note latency.
        do_reset();
        for (int i = 0; i < 8; i++) rom[i] = s0[i];
        clear_mon();
        pulse_pp();
        wait_for("first_note", 0, 1, 50);
        chk("first_note", int'(note_out), 5);
        chk("first_dur", int'(duration_to_load), 3);
        wait_for("one_beat", 2, 1, 50);
        pulse_pp();
        b0 = tot_beats; td0 = n_td;
        repeat (80) @(negedge clk);
        #4;
        chk("pause_beats", tot_beats, b0);
        chk("pause_done", n_td, td0);
        chk("pause_playing", int'(playing), 0);
        chk("pause_note", int'(note_out), 5);
        pulse_pp();
        wait_for("second_note", 0, 2, 100);
        chk("second_note", int'(note_out), 7);
        chk("second_dur", int'(duration_to_load), 1);
        chk("note5_beats", (q_beats.size() > 0) ? q_beats[0] : -1, 3);
        chk("advance_latency", last_lat, 3);
        chk("resume_playing", int'(playing), 1);

        // Restart during note 7.
        @(negedge clk);
        restart = 1'b1;
        #1;
        chk("restart_clear", int'(timer_clear), 1);
        @(negedge clk);
        restart = 1'b0;
        #1;
        chk("restart_addr", int'(rom_addr), 0);
        wait_for("restart_note", 0, 3, 20);
        chk("restart_note", int'(note_out), 5);
        chk("restart_dur", int'(duration_to_load), 3);

        // Restart and play_pause together in WAIT.
        repeat (2) @(negedge clk);
        restart = 1'b1; play_pause = 1'b1;
        @(negedge clk);
        restart = 1'b0; play_pause = 1'b0;
        #1;
        chk("rs_pp_playing", int'(playing), 1);
        chk("rs_pp_addr", int'(rom_addr), 0);
        wait_for("rs_pp_done", 1, 1, 200);
        repeat (2) @(negedge clk);
        chk("rs_pp_stop", int'(playing), 0);

        // Repeat mode loops back to the first note.
        do_reset();
        clear_mon();
        repeat_en = 1'b1;
        pulse_pp();
        wait_for("rep_done", 1, 1, 200);
        nd = done_cyc;
        wait_for("rep_note", 0, 3, 20);
        chk("rep_latency_le3", int'((new_cyc - nd) <= 3), 1);
        chk("rep_note", int'(note_out), 5);
        chk("rep_addr", int'(rom_addr), 0);
        chk("rep_playing", int'(playing), 1);
        repeat_en = 1'b0;
        wait_for("rep_stop", 1, 2, 200);
        repeat (2) @(negedge clk);
        chk("rep_stop_playing", int'(playing), 0);

        // Asynchronous reset mid-note.
        do_reset();
        clear_mon();
        pulse_pp();
        wait_for("ar_note", 0, 1, 50);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_addr", int'(rom_addr), 0);
        chk("ar_note", int'(note_out), 0);
        chk("ar_dur", int'(duration_to_load), 0);
        chk("ar_playing", int'(playing), 0);
        chk("ar_new_note", int'(new_note), 0);
        chk("ar_timer_clear", int'(timer_clear), 1);
        nd = n_done;
        repeat (3) @(negedge clk);
        chk("ar_no_done", n_done, nd);
        rst_n = 1'b1;

        // Random songs with random pauses against the word-list reference.
        for (int s = 0; s < 15; s++) begin
            int term, npause, pwait;
            bit paused, ok;
            term = $urandom_range(0, 8);
            exp_n.delete(); exp_d.delete();
            for (int i = 0; i < 8; i++) begin
                int n = $urandom_range(0, 63);
                int d = (i == term) ? 0 : $urandom_range(1, 5);
                rom[i] = mk(n, d);
            end
            for (int i = 0; i < 8; i++) begin
                if (rom[i][5:0] == 6'd0) break;
                exp_n.push_back(int'(rom[i][11:6]));
                exp_d.push_back(int'(rom[i][5:0]));
            end
            do_reset();
            clear_mon();
            pulse_pp();
            npause = 0; paused = 1'b0; pwait = 0; ok = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                play_pause = 1'b0;
                #4;
                if (n_done >= 1) begin ok = 1'b1; break; end
                if (paused) begin
                    pwait--;
                    if (pwait <= 0) begin play_pause = 1'b1; paused = 1'b0; end
                end else if (npause < 3 && have_note && cur_beats + 2 <= cur_dur &&
                             $urandom_range(0, 15) == 0) begin
                    play_pause = 1'b1; paused = 1'b1;
                    pwait = $urandom_range(4, 40);
                    npause++;
                end
            end
            if (!ok) chk($sformatf("rnd%0d_timeout", s), n_done, 1);
            repeat (2) @(negedge clk);
            #4;
            chk($sformatf("rnd%0d_count", s), q_notes.size(), exp_n.size());
            chk($sformatf("rnd%0d_beatcount", s), q_beats.size(), exp_d.size());
            foreach (exp_n[i]) begin
                if (i < q_notes.size() && i < q_beats.size()) begin
                    chk($sformatf("rnd%0d_note%0d", s, i), q_notes[i], exp_n[i]);
                    chk($sformatf("rnd%0d_dur%0d", s, i), q_durs[i], exp_d[i]);
                    chk($sformatf("rnd%0d_beats%0d", s, i), q_beats[i], exp_d[i]);
                end
            end
            chk($sformatf("rnd%0d_done", s), n_done, 1);
            chk($sformatf("rnd%0d_playing", s), int'(playing), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
